mem_c: RTL and testbench
========================

MEM_C -- requirements
Module: mem_c

Interface
REQ-001 Parameter BITS_C, default 16, signed width of one result element.
REQ-002 Parameter DIM, default 8, systolic array dimension; ROWBITS = $clog2(DIM).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse beginning a capture of one skewed DIMxDIM result tile.
REQ-006 en  input  1  capture-advance qualifier; en low stalls the capture.
REQ-007 clr  input  1  synchronous zeroing of all storage.
REQ-008 Cin  input  signed [BITS_C-1:0] x DIM  skewed result lanes from the array; lane i carries row i.
REQ-009 Crow  input  ROWBITS  read row address.
REQ-010 Cout  output  signed [BITS_C-1:0] x DIM  registered read data, row Crow, lane j = column j.
REQ-011 busy  output  1  high while in CAPTURE.
REQ-012 done  output  1  high while in DONE.

Function
REQ-013 Storage: DIM x DIM array mem[row][col] of BITS_C signed elements.
REQ-014 FSM states: IDLE, CAPTURE, DONE; IDLE->CAPTURE and DONE->CAPTURE on start; CAPTURE->DONE on the final capture cycle.
REQ-015 Capture counter cnt runs 0..2*DIM-2; it is cleared on entry to CAPTURE and increments only on cycles with busy=1 and en=1.
REQ-016 On a CAPTURE cycle with en=1, lane i writes Cin[i] into mem[i][cnt-i] if and only if 0 <= cnt-i <= DIM-1; all other lanes are ignored that cycle.
REQ-017 The cycle with en=1 and cnt=2*DIM-2 is the last write; busy falls and done rises on the following edge.
REQ-018 en=0 during CAPTURE holds cnt and storage unchanged.
REQ-019 start while busy=1 is ignored.
REQ-020 start and en high in the same cycle in IDLE or DONE: transition only; no write occurs that cycle.
REQ-021 done stays high until the next accepted start or reset.
REQ-022 Read: Cout <= mem[Crow] every cycle; latency is 1 clock; there is no read enable.
REQ-023 A read of a row being written in the same cycle returns the pre-write value; reads during CAPTURE return partial contents.
REQ-024 clr zeroes all of mem on the next edge when busy=0; clr is ignored while busy=1.
REQ-025 clr and start in the same cycle: storage is zeroed and CAPTURE entered on the same edge.

Reset
REQ-026 While rst=1: state=IDLE, cnt=0, busy=0, done=0, Cout all zero, mem all zero.
REQ-027 Reset mid-CAPTURE discards the partial tile; no write occurs on the edge at which rst deasserts.

Configuration
REQ-028 Macro MEMC_ACCUM_EN, when defined, makes each REQ-016 write store sat(mem[i][cnt-i] + Cin[i]), saturated to the signed BITS_C range, for K-tiled accumulation.
REQ-029 Without MEMC_ACCUM_EN, REQ-016 writes overwrite the stored value and no adder exists.

Verification
REQ-030 Reset mid-capture: assert rst at cnt=5 -> next cycle busy=0, done=0, Cout=0 for every Crow.
REQ-031 Basic capture: start, en=1 continuously, Cin[i]=C[i][t-i] with C[r][c]=16*r+c -> done rises 2*DIM-1=15 cycles after the first capture cycle; Crow=3 returns 48..55 one cycle later.
REQ-032 Stall: en low for 3 cycles at cnt=4 -> done delayed by exactly 3 cycles; stored tile identical to REQ-031.
REQ-033 Ignored start: pulse start at cnt=7 -> cnt is not restarted and done timing is unchanged.
REQ-034 clr: after done, pulse clr then read Crow=0..7 -> all zero; clr pulsed during CAPTURE leaves contents intact.
REQ-035 MEMC_ACCUM_EN: capture tile of 30000 twice -> every element reads 32767; tile of -20000 twice -> -32768; without the macro, the second capture gives 30000 and -20000.

Source files
------------

// File: rtl/mem_c_if.sv
// mem_c_if: bundles the mem_c control and data bus.
//   master : drives start, en, clr, Cin, Crow; observes Cout, busy, done
//   slave  : the mem_c side of the same signals
// Cin[i] carries the skewed result of array row i. Cout[j] is column j of
// the row addressed by Crow.
interface mem_c_if #(
  parameter int BITS_C = 16,
  parameter int DIM    = 8
);
  localparam int ROWBITS = (DIM > 1) ? $clog2(DIM) : 1;

  logic                     start;
  logic                     en;
  logic                     clr;
  logic signed [BITS_C-1:0] Cin  [DIM];
  logic [ROWBITS-1:0]       Crow;
  logic signed [BITS_C-1:0] Cout [DIM];
  logic                     busy;
  logic                     done;

  modport master (
    output start, en, clr, Cin, Crow,
    input  Cout, busy, done
  );

  modport slave (
    input  start, en, clr, Cin, Crow,
    output Cout, busy, done
  );
endinterface

// File: rtl/mem_c.sv
// mem_c: result tile memory behind a DIM x DIM systolic array.
// Captures one skewed result tile into a DIM x DIM store and serves
// registered row reads.
//
// Ports:
//   clk        : single clock, rising edge
//   rst        : asynchronous active-high reset (clears FSM, store and read data)
//   bus.start  : one-cycle pulse starting a capture (ignored while busy)
//   bus.en     : capture-advance qualifier; low stalls the capture
//   bus.clr    : synchronous zeroing of the store when not busy
//   bus.Cin    : skewed lanes; lane i carries row i, column (cnt - i)
//   bus.Crow   : read row address
//   bus.Cout   : registered read data for row Crow (1-cycle latency)
//   bus.busy   : high while capturing
//   bus.done   : high from the end of a capture until the next accepted start
//
// Build option: define MEMC_ACCUM_EN to make every capture write a
// saturating accumulate (stored + Cin) instead of an overwrite, so several
// K-tiles can be summed in place.
module mem_c #(
  parameter int BITS_C = 16,
  parameter int DIM    = 8
) (
  input  logic   clk,
  input  logic   rst,
  mem_c_if.slave bus
);

  localparam int ROWBITS = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int CNTW    = $clog2(2 * DIM);
  localparam int LAST    = 2 * DIM - 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t                   state;
  logic [CNTW-1:0]          cnt;
  logic                     busy;
  logic                     done;
  logic signed [BITS_C-1:0] mem   [DIM][DIM];
  logic signed [BITS_C-1:0] rd_p1 [DIM];
  logic [ROWBITS-1:0]       rd_row;

  assign rd_row = bus.Crow;

`ifdef MEMC_ACCUM_EN
  localparam logic signed [BITS_C-1:0] SMAX = {1'b0, {(BITS_C-1){1'b1}}};
  localparam logic signed [BITS_C-1:0] SMIN = {1'b1, {(BITS_C-1){1'b0}}};

  // One guard bit is enough to detect overflow of a two-operand add.
  function automatic logic signed [BITS_C-1:0] sat_add(
    input logic signed [BITS_C-1:0] a,
    input logic signed [BITS_C-1:0] b
  );
    logic signed [BITS_C:0] s;
    s = (BITS_C+1)'(a) + (BITS_C+1)'(b);
    if (s[BITS_C] != s[BITS_C-1]) begin
      return s[BITS_C] ? SMIN : SMAX;
    end
    return s[BITS_C-1:0];
  endfunction
`endif

  // Control: state, capture counter and the registered busy/done flags.
  // Entering CAPTURE always restarts cnt; the start cycle itself never
  // writes because writes are qualified by busy, which is still low then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state <= CAPTURE;
            cnt   <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        CAPTURE: begin
          if (bus.en) begin
            if (cnt == CNTW'(LAST)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Storage write and read register (stage p1).
  // Lane r lands in column c exactly when cnt == r + c, which is the
  // de-skew of the array's diagonal wavefront. The read samples mem before
  // this edge's write, so a same-cycle read of a written row sees old data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DIM; r++) begin
        for (int c = 0; c < DIM; c++) begin
          mem[r][c] <= '0;
        end
      end
      for (int j = 0; j < DIM; j++) begin
        rd_p1[j] <= '0;
      end
    end else begin
      if (bus.clr && !busy) begin
        for (int r = 0; r < DIM; r++) begin
          for (int c = 0; c < DIM; c++) begin
            mem[r][c] <= '0;
          end
        end
      end else if (busy && bus.en) begin
        for (int r = 0; r < DIM; r++) begin
          for (int c = 0; c < DIM; c++) begin
            if (cnt == CNTW'(r + c)) begin
`ifdef MEMC_ACCUM_EN
              mem[r][c] <= sat_add(mem[r][c], bus.Cin[r]);
`else
              mem[r][c] <= bus.Cin[r];
`endif
            end
          end
        end
      end
      for (int j = 0; j < DIM; j++) begin
        rd_p1[j] <= mem[rd_row][j];
      end
    end
  end

  assign bus.Cout = rd_p1;
  assign bus.busy = busy;
  assign bus.done = done;

endmodule

// File: tb/tb_mem_c.sv
// tb_mem_c: scoreboard bench for mem_c. A reference tile model is updated
// whenever a capture is driven; row reads push the model's expected row
// into a queue and the registered DUT output is popped and compared one
// cycle later.
module tb_mem_c;

  localparam int W   = 16;
  localparam int DIM = 8;

  logic clk;
  logic rst;

  int checks   = 0;
  int failures = 0;

  int model [DIM][DIM];
  logic signed [W-1:0] exp_q [$];

  mem_c_if #(.BITS_C(W), .DIM(DIM)) bus ();

  mem_c #(.BITS_C(W), .DIM(DIM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int tile_val(input int kind, input int r, input int c);
    case (kind)
      0:       return 16 * r + c;
      1:       return 30000;
      default: return -20000;
    endcase
  endfunction

  function automatic int sat16(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic model_zero();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        model[r][c] = 0;
  endtask

  task automatic model_apply(input int kind);
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
`ifdef MEMC_ACCUM_EN
        model[r][c] = sat16(model[r][c] + tile_val(kind, r, c));
`else
        model[r][c] = tile_val(kind, r, c);
`endif
      end
  endtask

  task automatic drive_garbage();
    for (int i = 0; i < DIM; i++) bus.Cin[i] = W'($urandom);
  endtask

  task automatic drive_lanes(input int kind, input int t);
    for (int i = 0; i < DIM; i++) begin
      if (t - i >= 0 && t - i < DIM) bus.Cin[i] = W'(tile_val(kind, i, t - i));
      else                           bus.Cin[i] = W'($urandom);
    end
  endtask

  // Read every row; expected row pushed when address driven, popped after
  // the one-cycle read latency.
  task automatic read_tile(input string tag);
    logic signed [W-1:0] e;
    for (int r = 0; r < DIM; r++) begin
      bus.Crow = 3'(r);
      for (int j = 0; j < DIM; j++) exp_q.push_back(W'(model[r][j]));
      @(negedge clk);
      for (int j = 0; j < DIM; j++) begin
        e = exp_q.pop_front();
        check($sformatf("%s_r%0d_c%0d", tag, r, j), bus.Cout[j], e);
      end
    end
  endtask

  // One capture. stall_at/stall_len: en low for stall_len cycles at cnt=stall_at.
  // ign_at: start pulse while busy. clr_at: clr pulse while busy.
  // clr_start: clr together with the accepted start. rst_at: reset mid-capture.
  task automatic capture(input string tag, input int kind, input int stall_at,
                         input int stall_len, input int ign_at, input int clr_at,
                         input bit clr_start, input int rst_at);
    int  t;
    int  lat;
    int  stalled;
    bit  en_now;
    @(negedge clk);
    bus.start = 1'b1;
    bus.en    = 1'b1;
    bus.clr   = clr_start;
    drive_garbage();
    if (clr_start) model_zero();
    @(negedge clk);
    bus.start = 1'b0;
    bus.clr   = 1'b0;
    check({tag, "_busy_start"}, bus.busy, 1);
    check({tag, "_done_start"}, bus.done, 0);
    t = 0; lat = 0; stalled = 0;
    while (lat < 64) begin
      if (t == rst_at) begin
        rst = 1'b1;
        bus.en = 1'b0;
        @(negedge clk);
        check({tag, "_rst_busy"}, bus.busy, 0);
        check({tag, "_rst_done"}, bus.done, 0);
        for (int r = 0; r < DIM; r++) begin
          bus.Crow = 3'(r);
          @(negedge clk);
          for (int j = 0; j < DIM; j++)
            check($sformatf("%s_rst_cout_r%0d_c%0d", tag, r, j), bus.Cout[j], 0);
        end
        rst = 1'b0;
        model_zero();
        return;
      end
      en_now = !(t == stall_at && stalled < stall_len);
      bus.en = en_now;
      if (en_now) drive_lanes(kind, t);
      else begin drive_garbage(); stalled++; end
      bus.start = (t == ign_at);
      bus.clr   = (t == clr_at);
      @(negedge clk);
      lat++;
      bus.start = 1'b0;
      bus.clr   = 1'b0;
      if (en_now) t++;
      if (bus.done) break;
    end
    bus.en = 1'b0;
    check({tag, "_latency"}, lat, 2 * DIM - 1 + stall_len);
    check({tag, "_busy_end"}, bus.busy, 0);
    model_apply(kind);
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.en    = 1'b0;
    bus.clr   = 1'b0;
    bus.Crow  = '0;
    for (int i = 0; i < DIM; i++) bus.Cin[i] = '0;
    model_zero();
    repeat (3) @(negedge clk);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_cout0", bus.Cout[0], 0);
    check("reset_cout7", bus.Cout[DIM-1], 0);
    rst = 1'b0;
    read_tile("reset_mem");

    // Basic capture, start issued with en high (no write on that cycle).
    capture("basic", 0, -1, 0, -1, -1, 1'b0, -1);
    check("basic_done_hold", bus.done, 1);
    read_tile("basic");

    // clr after done zeroes everything.
    @(negedge clk);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    model_zero();
    read_tile("clr");

    // Stall three cycles at cnt=4.
    capture("stall", 0, 4, 3, -1, -1, 1'b0, -1);
    read_tile("stall");

    // clr+start together from DONE, then ignored clr and start while busy.
    capture("ign", 0, -1, 0, 7, 6, 1'b1, -1);
    read_tile("ign");

    // Reset at cnt=5 discards the partial tile and clears the store.
    capture("rstmid", 0, -1, 0, -1, -1, 1'b0, 5);
    check("rstmid_busy_after", bus.busy, 0);
    read_tile("rstmid");

    // Positive saturation (accumulate build) or overwrite.
    capture("pos1", 1, -1, 0, -1, -1, 1'b0, -1);
    capture("pos2", 1, -1, 0, -1, -1, 1'b0, -1);
    read_tile("pos");

    // Negative saturation after an explicit clear.
    @(negedge clk);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    model_zero();
    capture("neg1", 2, -1, 0, -1, -1, 1'b0, -1);
    capture("neg2", 2, -1, 0, -1, -1, 1'b0, -1);
    read_tile("neg");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
